// File: rtl/sram_bus_arbiter.sv
// Arbitrates NUM_MASTERS SRAM-like requesters onto one SRAM-like slave, routing responses via an
// in-order ownership FIFO. Define SRAM_ARB_RR_EN for round-robin; otherwise fixed priority.
module sram_bus_arbiter #(
  parameter int unsigned NUM_MASTERS     = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [2*NUM_MASTERS-1:0]  m_size,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_addr_ok,
  output logic [NUM_MASTERS-1:0]    m_data_ok,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [31:0]               s_rdata,
  output logic                      err_underflow
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic [IdxW-1:0] grant;
  logic [IdxW-1:0] prio;
  logic [IdxW-1:0] cand_idx;
  logic            found;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] tag_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q;
  logic            full, accept, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A locked grant holds the slave-side fields stable until acceptance.
  always_comb begin
    grant    = prio;
    found    = 1'b0;
    cand_idx = '0;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
        cand_idx = IdxW'((32'(prio) + 32'(k)) % NUM_MASTERS);
        if (!found && m_req[cand_idx]) begin
          grant = cand_idx;
          found = 1'b1;
        end
      end
    end
  end

  assign full    = (count_q == CntW'(MAX_OUTSTANDING));
  assign s_req   = (|m_req) && m_req[grant] && !full;
  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[2*grant +: 2];
  assign s_addr  = m_addr[32*grant +: 32];
  assign s_wdata = m_wdata[32*grant +: 32];

  assign accept    = s_req && s_addr_ok;
  assign pop       = s_data_ok && (count_q != '0);
  assign m_addr_ok = accept ? (NUM_MASTERS'(1) << grant) : '0;
  assign m_data_ok = pop ? (NUM_MASTERS'(1) << tag_q[head_q]) : '0;
  assign m_rdata   = s_rdata;

  assign err_underflow = err_q;

  always_comb begin
    lock_d     = s_req && !s_addr_ok;
    lock_idx_d = lock_d ? grant : lock_idx_q;
    count_d    = count_q + CntW'(accept) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      if (accept) tail_q <= ptr_inc(tail_q);
      if (pop) head_q <= ptr_inc(head_q);
      if (s_data_ok && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tail_q] <= grant;
  end

`ifdef SRAM_ARB_RR_EN
  logic [IdxW-1:0] prio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= '0;
    end else if (accept) begin
      prio_q <= (grant == IdxW'(NUM_MASTERS - 1)) ? '0 : grant + IdxW'(1);
    end
  end

  assign prio = prio_q;
`else
  assign prio = '0;
`endif

endmodule
